// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: response-state encoding and streak counter width shared by the arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_RESP_I, ARB_RESP_D} arb_state_e;
    localparam int ARB_STREAK_W = 4;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, data first, read data routed back a cycle later.
// Define ARBITER_FAIRNESS_EN to add the streak counter that lets fetch through after MAX_DATA_STREAK data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        mem_ready,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    arb_state_e state_q, state_d;
    logic       fetch_ovr;

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_range
        $error("MAX_DATA_STREAK must be 1..15");
    end

`ifdef ARBITER_FAIRNESS_EN
    localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_DATA_STREAK);
    logic [ARB_STREAK_W-1:0] streak_q, streak_d;
    assign fetch_ovr = i_req && streak_q == STREAK_MAX;
    always_comb begin
        streak_d = (i_gnt || !i_req) ? '0 :
                   (d_gnt && streak_q != STREAK_MAX) ? streak_q + 1'b1 : streak_q;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) streak_q <= '0;
        else          streak_q <= streak_d;
    end
`else
    assign fetch_ovr = 1'b0;
`endif

    // Grants are forced low during reset so nothing reaches memory whatever the requesters do.
    assign d_gnt = reset_n && mem_ready && d_req && !fetch_ovr;
    assign i_gnt = reset_n && mem_ready && i_req && (!d_req || fetch_ovr);

    always_comb begin
        mem_en    = i_gnt || d_gnt;
        mem_addr  = d_gnt ? d_addr : i_gnt ? i_addr : '0;
        mem_we    = d_gnt ? d_we : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        state_d   = i_gnt ? ARB_RESP_I : (d_gnt && d_we == '0) ? ARB_RESP_D : ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    // Masking with reset_n drops a pending response as soon as reset is applied.
    always_comb begin
        i_rvalid = reset_n && state_q == ARB_RESP_I;
        d_rvalid = reset_n && state_q == ARB_RESP_D;
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; a per-cycle reference model queues expected accesses and read responses.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, mem_ready = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_we = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ig;
        logic        dg;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    int tests = 0;
    int fails = 0;
    int streak = 0;
    int prev = 0;

    task automatic step(input logic rn, input logic rdy, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic [31:0] da, input logic [3:0] dw,
                        input logic [31:0] dwd, input logic [31:0] rd, output int win);
        bit fair;
        acc_t a;
        @(posedge clk);
        #1;
        reset_n = rn; mem_ready = rdy; i_req = ir; i_addr = ia;
        d_req = dr; d_addr = da; d_we = dw; d_wdata = dwd; mem_rdata = rd;
        if (rn && prev == 1) iq.push_back(rd);
        if (rn && prev == 2) dq.push_back(rd);
`ifdef ARBITER_FAIRNESS_EN
        fair = (streak == MAXS);
`else
        fair = 1'b0;
`endif
        win = 0;
        if (rn && rdy) win = (ir && (!dr || fair)) ? 1 : dr ? 2 : 0;
        if (win == 1) begin
            a.ig = 1; a.dg = 0; a.addr = ia; a.we = '0; a.wdata = '0;
            acc_q.push_back(a);
        end else if (win == 2) begin
            a.ig = 0; a.dg = 1; a.addr = da; a.we = dw; a.wdata = dwd;
            acc_q.push_back(a);
        end
        if (!rn || win == 1 || !ir) streak = 0;
        else if (win == 2 && streak < MAXS) streak++;
        prev = (win == 1) ? 1 : (win == 2 && dw == 4'd0) ? 2 : 0;
    endtask

    always @(negedge clk) begin
        acc_t e;
        logic [31:0] r;
        if (mem_en || i_gnt || d_gnt) begin
            tests++;
            if (acc_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_grant i_gnt=%b d_gnt=%b mem_en=%b addr=%h, required none", i_gnt, d_gnt, mem_en, mem_addr);
            end else begin
                e = acc_q.pop_front();
                if ({i_gnt, d_gnt, mem_en, mem_addr, mem_we, mem_wdata} !== {e.ig, e.dg, 1'b1, e.addr, e.we, e.wdata}) begin
                    fails++;
                    $display("FAIL access got ig=%b dg=%b en=%b addr=%h we=%b wd=%h, required ig=%b dg=%b en=1 addr=%h we=%b wd=%h",
                             i_gnt, d_gnt, mem_en, mem_addr, mem_we, mem_wdata, e.ig, e.dg, e.addr, e.we, e.wdata);
                end
            end
        end else begin
            tests++;
            if ({mem_addr, mem_we, mem_wdata} !== '0) begin
                fails++;
                $display("FAIL idle_port got addr=%h we=%b wd=%h, required 0", mem_addr, mem_we, mem_wdata);
            end
        end
        tests++;
        if (i_rvalid) begin
            if (iq.size() == 0) begin
                fails++;
                $display("FAIL i_resp unexpected i_rvalid rdata=%h, required no response", i_rdata);
            end else begin
                r = iq.pop_front();
                if (i_rdata !== r) begin
                    fails++;
                    $display("FAIL i_resp got %h required %h", i_rdata, r);
                end
            end
        end else if (i_rdata !== '0) begin
            fails++;
            $display("FAIL i_rdata_idle got %h required 0", i_rdata);
        end
        tests++;
        if (d_rvalid) begin
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL d_resp unexpected d_rvalid rdata=%h, required no response", d_rdata);
            end else begin
                r = dq.pop_front();
                if (d_rdata !== r) begin
                    fails++;
                    $display("FAIL d_resp got %h required %h", d_rdata, r);
                end
            end
        end else if (d_rdata !== '0) begin
            fails++;
            $display("FAIL d_rdata_idle got %h required 0", d_rdata);
        end
    end

    initial begin
        int w;
        logic ip, dp, rn, rdy;
        logic [31:0] ia, da, dwd;
        logic [3:0] dw;
        step(0, 1, 1, 32'h100, 1, 32'h2000, 4'd0, 32'h0, $urandom, w);
        step(0, 1, 1, 32'h100, 1, 32'h2000, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 1, 32'h100, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, 32'hDEADBEEF, w);
        step(1, 1, 1, 32'h104, 1, 32'h2000, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 1, 32'h104, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 1, 32'h2002, 4'b0011, 32'h0000BEEF, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        for (int i = 0; i < 6; i++)
            step(1, 1, 1, 32'h200 + 32'(i * 4), 1, 32'h3000 + 32'(i * 4), 4'd0, 32'h0, $urandom, w);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 32'h300, 1, 32'h3100, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 1, 32'h4000, 4'd0, 32'h0, $urandom, w);
        step(0, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        ip = 0; dp = 0; ia = '0; da = '0; dw = '0; dwd = '0;
        for (int i = 0; i < 500; i++) begin
            if (!ip) begin
                ip = 1'($urandom_range(0, 1));
                ia = $urandom;
            end
            if (!dp) begin
                dp = 1'($urandom_range(0, 1));
                da = $urandom;
                dw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
                dwd = $urandom;
            end
            rn = ($urandom_range(0, 49) != 0);
            rdy = ($urandom_range(0, 4) != 0);
            step(rn, rdy, ip, ia, dp, da, dw, dwd, $urandom, w);
            if (w == 1) ip = 0;
            if (w == 2) dp = 0;
        end
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        step(1, 1, 0, 32'h0, 0, 32'h0, 4'd0, 32'h0, $urandom, w);
        @(negedge clk);
        #1;
        tests++;
        if (acc_q.size() + iq.size() + dq.size() != 0) begin
            fails++;
            $display("FAIL leftover got acc=%0d iresp=%0d dresp=%0d outstanding, required 0", acc_q.size(), iq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-port memory between the instruction fetch stage and the load/store unit. Each cycle it grants at most one requester, drives the memory port, and routes the read data returned one cycle later back to the requester that issued the read. It sits between the pipeline (fetch and execute stages) and the memory interface. Data accesses have priority; an optional fairness counter prevents fetch starvation.

## Interface

**Parameters**

- `MAX_DATA_STREAK`, default 4: maximum consecutive data grants while fetch is waiting (fairness build only); legal range 1–15.

**Ports**

- `clk`  in  1  core clock
- `reset_n`  in  1  reset, synchronous and active-low (one clock; polarity and synchronicity are fixed)
- `i_req`  in  1  fetch read request
- `i_addr`  in  32  fetch address
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  fetch read data valid
- `i_rdata`  out  32  fetch read data
- `d_req`  in  1  LSU request
- `d_addr`  in  32  LSU address
- `d_we`  in  4  LSU byte write enables; 0 = read
- `d_wdata`  in  32  LSU write data
- `d_gnt`  out  1  LSU request accepted this cycle
- `d_rvalid`  out  1  LSU read data valid
- `d_rdata`  out  32  LSU read data
- `mem_ready`  in  1  memory can accept an access this cycle
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  4  memory byte write enables
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_rdata`  in  32  memory read data, valid the cycle after an accepted read

## Operation

- **Grant (combinational).** Grant only when `mem_ready` = 1.
  - Default: `d_req` wins over `i_req`.
  - Fairness build only: fetch wins when `streak` = `MAX_DATA_STREAK` and `i_req` = 1.
- **Memory port.**
  - `mem_en` = `i_gnt | d_gnt`.
  - `mem_addr`, `mem_we` and `mem_wdata` come from the granted requester.
  - A fetch grant forces `mem_we` = 0 and `mem_wdata` = 0.
  - With no grant, all memory outputs are 0.
- **Response FSM.** States are ARB_IDLE, ARB_RESP_I and ARB_RESP_D, evaluated at each clock edge:
  - A granted fetch moves to ARB_RESP_I.
  - A granted data read (`d_we` = 0) moves to ARB_RESP_D.
  - A granted write, or no grant, moves to ARB_IDLE.
  - Transitions from any state are identical. A new grant is allowed in the same cycle a response returns.
- **Response outputs.**
  - `i_rvalid` = (state == ARB_RESP_I); `d_rvalid` = (state == ARB_RESP_D).
  - `i_rdata` = `mem_rdata` when `i_rvalid` = 1, else 0. `d_rdata` follows the same rule with `d_rvalid`.
- **Writes** complete at grant and produce no rvalid.
- **Streak counter** (4 bits, fairness build only):
  - Increments on each `d_gnt` while `i_req` = 1.
  - Clears on `i_gnt`, or on any cycle with `i_req` = 0.
  - Saturates at `MAX_DATA_STREAK`.
- **Requester obligations.** A requester holds `req`, `addr`, `we` and `wdata` stable until it is granted. The arbiter does not register requests.

## Timing

- Grant latency: 0 cycles (same cycle as `req`, when the request wins and `mem_ready` = 1).
- Read data latency: exactly 1 cycle after grant.
- Throughput: one access per cycle; back-to-back reads from either side run without bubbles.
- Reset values, with `reset_n` = 0 sampled at an edge:
  - state = ARB_IDLE, `streak` = 0.
  - `i_rvalid`, `d_rvalid`, `i_rdata`, `d_rdata` = 0.
  - Grants and memory outputs are 0 while `reset_n` = 0, whatever the requests.
- Reset mid-read: the pending response is dropped, and no rvalid appears in the cycle after reset.
- `mem_ready` = 0: no grant; the FSM still retires any pending response, then goes to ARB_IDLE.
- Simultaneous requests: exactly one grant, never both.

## Configuration

- `ARBITER_FAIRNESS_EN` defined: the streak counter and the fetch override are compiled in.
- `ARBITER_FAIRNESS_EN` undefined: strict data priority, no counter logic, and `MAX_DATA_STREAK` is unused.

## Structure

- Shared package holds:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_RESP_I, ARB_RESP_D} arb_state_e`
  - localparam `ARB_STREAK_W` = 4
- Single module; no sub-module is warranted.

## Test plan

- Reset: hold `reset_n` = 0 with `i_req` = `d_req` = 1 → `mem_en` = 0, both gnt = 0, both rvalid = 0.
- Single fetch: `i_req` = 1, `i_addr` = 0x100, `mem_rdata` = 0xDEADBEEF next cycle → `i_gnt` = 1, `mem_addr` = 0x100, `mem_we` = 0; one cycle later `i_rvalid` = 1 and `i_rdata` = 0xDEADBEEF.
- Conflict: `i_req` and `d_req` both asserted, `d_addr` = 0x2000, `d_we` = 0 → `d_gnt` = 1, `i_gnt` = 0; next cycle `d_rvalid` = 1, `i_gnt` = 1.
- Store: `d_we` = 4'b0011, `d_wdata` = 0x0000BEEF, `d_addr` = 0x2002 → `mem_we` = 0011, `mem_addr` = 0x2002; no `d_rvalid` follows.
- Fairness (`ARBITER_FAIRNESS_EN`, `MAX_DATA_STREAK` = 4): `i_req` and `d_req` held for 6 cycles → grant sequence D, D, D, D, I, D. Undefined build → D on all 6 cycles.
- Stall and reset mid-read: `mem_ready` = 0 for 3 cycles → no grants. Then assert `reset_n` = 0 in the cycle after a data read grant → `d_rvalid` stays 0.
